floo_ring_on_mesh_mcast_injector: RTL and testbench

FLOO_RING_ON_MESH_MCAST_INJECTOR -- requirements
Module: floo_ring_on_mesh_mcast_injector

---
 rtl/floo_ring_on_mesh_mcast_injector_pkg.sv | 28 ++
 rtl/floo_ring_on_mesh_target_find.sv | 36 +++
 rtl/floo_ring_on_mesh_mcast_injector.sv | 170 +++++++++++++++++
 tb/tb_floo_ring_on_mesh_mcast_injector.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/floo_ring_on_mesh_mcast_injector_pkg.sv
// Shared types for the ring-on-mesh multicast injector: FSM states and the default flit layout.
package floo_pkg;

    localparam int unsigned DefNumNodes = 16;
    localparam int unsigned DefIdW      = $clog2(DefNumNodes);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FILL      = 3'd1,
        SEND_UP   = 3'd2,
        SEND_DOWN = 3'd3,
        DROP      = 3'd4
    } inj_state_e;

    typedef struct packed {
        logic [DefIdW-1:0]      dst_id;
        logic                   ring_on_mesh_mcast;
        logic [DefNumNodes-1:0] ring_on_mesh_dst_mask;
        logic                   up_down_traffic;
        logic                   last;
    } ring_hdr_t;

    typedef struct packed {
        ring_hdr_t   hdr;
        logic [31:0] payload;
    } ring_flit_t;

endpackage

// File: rtl/floo_ring_on_mesh_target_find.sv
// Combinational priority search for the farthest multicast destination on each
// side of the own ring position: highest set index above, lowest set index below.
module floo_ring_on_mesh_target_find #(
    parameter int unsigned NumNodes = 16
) (
    input  logic [NumNodes-1:0]         mask_i,
    input  logic [$clog2(NumNodes)-1:0] id_i,
    output logic [$clog2(NumNodes)-1:0] up_id_o,
    output logic                        up_found_o,
    output logic [$clog2(NumNodes)-1:0] down_id_o,
    output logic                        down_found_o
);

    localparam int unsigned IdW = $clog2(NumNodes);

    always_comb begin
        up_id_o      = '0;
        up_found_o   = 1'b0;
        down_id_o    = '0;
        down_found_o = 1'b0;
        // Ascending scan: the last hit above the own id is the highest one.
        for (int i = 0; i < int'(NumNodes); i++) begin
            if (mask_i[i] && (i > int'(id_i))) begin
                up_found_o = 1'b1;
                up_id_o    = IdW'(i);
            end
        end
        for (int i = int'(NumNodes) - 1; i >= 0; i--) begin
            if (mask_i[i] && (i < int'(id_i))) begin
                down_found_o = 1'b1;
                down_id_o    = IdW'(i);
            end
        end
    end

endmodule

// File: rtl/floo_ring_on_mesh_mcast_injector.sv
// Buffers one local packet, then replays it once towards the farthest multicast
// destination above the own ring position and once towards the farthest below.
module floo_ring_on_mesh_mcast_injector
    import floo_pkg::*;
#(
    parameter int unsigned NumNodes = 16,
    parameter int unsigned MaxFlits = 4,
    parameter type         flit_t   = floo_pkg::ring_flit_t
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [$clog2(NumNodes)-1:0] ring_on_mesh_id_i,
    input  logic                        valid_i,
    output logic                        ready_o,
    input  flit_t                       data_i,
    output logic                        valid_o,
    input  logic                        ready_i,
    output flit_t                       data_o,
    output logic                        busy_o,
    output logic                        err_o
);

    localparam int unsigned IdW  = $clog2(NumNodes);
    localparam int unsigned CntW = $clog2(MaxFlits + 1);
    localparam int unsigned IdxW = (MaxFlits > 1) ? $clog2(MaxFlits) : 1;

    inj_state_e          state_q;
    logic [CntW-1:0]     wr_ptr_q, rd_ptr_q, n_q;
    flit_t               mem_q [MaxFlits];
    logic                valid_q, err_q;
    flit_t               data_q;
    logic                ucast_q, has_down_q;
    logic [IdW-1:0]      up_id_q, down_id_q;
    logic [NumNodes-1:0] mask_q;

    logic                in_hs, out_hs, last_slot;
    logic [CntW-1:0]     rd_nxt;
    flit_t               first_flit;
    logic [NumNodes-1:0] plan_mask;
    logic [IdW-1:0]      up_id, down_id;
    logic                up_found, down_found;

    function automatic flit_t mod_flit(input flit_t f, input logic ucast, input logic up,
                                       input logic [IdW-1:0] dst, input logic [NumNodes-1:0] m);
        flit_t r;
        r = f;
        if (!ucast) begin
            r.hdr.dst_id                = dst;
            r.hdr.up_down_traffic       = up;
            r.hdr.ring_on_mesh_dst_mask = m;
        end
        return r;
    endfunction

    assign ready_o   = !rst_i && (state_q inside {IDLE, FILL, DROP});
    assign busy_o    = !rst_i && (state_q != IDLE);
    assign valid_o   = valid_q;
    assign data_o    = data_q;
    assign err_o     = err_q;
    assign in_hs     = valid_i && ready_o;
    assign out_hs    = valid_q && ready_i;
    assign last_slot = (wr_ptr_q == CntW'(MaxFlits - 1));
    assign rd_nxt    = rd_ptr_q + CntW'(1);

    // A single-flit packet is planned straight from the input, before slot 0 is written.
    assign first_flit = (wr_ptr_q == '0) ? data_i : mem_q[0];
    assign plan_mask  = first_flit.hdr.ring_on_mesh_dst_mask & ~(NumNodes'(1) << ring_on_mesh_id_i);

    floo_ring_on_mesh_target_find #(
        .NumNodes (NumNodes)
    ) i_target_find (
        .mask_i       (plan_mask),
        .id_i         (ring_on_mesh_id_i),
        .up_id_o      (up_id),
        .up_found_o   (up_found),
        .down_id_o    (down_id),
        .down_found_o (down_found)
    );

    always_ff @(posedge clk_i) begin
        if (in_hs && (state_q != DROP)) begin
            mem_q[wr_ptr_q[IdxW-1:0]] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            n_q        <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            data_q     <= '0;
            ucast_q    <= 1'b0;
            has_down_q <= 1'b0;
            up_id_q    <= '0;
            down_id_q  <= '0;
            mask_q     <= '0;
        end else begin
            err_q <= 1'b0;
            unique case (state_q)
                IDLE, FILL: begin
                    if (in_hs) begin
                        if (data_i.hdr.last) begin
                            wr_ptr_q   <= '0;
                            rd_ptr_q   <= '0;
                            n_q        <= wr_ptr_q + CntW'(1);
                            ucast_q    <= !first_flit.hdr.ring_on_mesh_mcast;
                            mask_q     <= plan_mask;
                            up_id_q    <= up_id;
                            down_id_q  <= down_id;
                            has_down_q <= down_found && first_flit.hdr.ring_on_mesh_mcast;
                            if (!first_flit.hdr.ring_on_mesh_mcast) begin
                                state_q <= SEND_UP;
                                valid_q <= 1'b1;
                                data_q  <= first_flit;
                            end else if (plan_mask == '0) begin
                                state_q <= IDLE;
                                err_q   <= 1'b1;
                            end else if (up_found) begin
                                state_q <= SEND_UP;
                                valid_q <= 1'b1;
                                data_q  <= mod_flit(first_flit, 1'b0, 1'b1, up_id, plan_mask);
                            end else begin
                                state_q <= SEND_DOWN;
                                valid_q <= 1'b1;
                                data_q  <= mod_flit(first_flit, 1'b0, 1'b0, down_id, plan_mask);
                            end
                        end else if (last_slot) begin
                            state_q  <= DROP;
                            err_q    <= 1'b1;
                            wr_ptr_q <= '0;
                        end else begin
                            state_q  <= FILL;
                            wr_ptr_q <= wr_ptr_q + CntW'(1);
                        end
                    end
                end
                SEND_UP, SEND_DOWN: begin
                    if (out_hs) begin
                        if (rd_nxt < n_q) begin
                            rd_ptr_q <= rd_nxt;
                            data_q   <= mod_flit(mem_q[rd_nxt[IdxW-1:0]], ucast_q,
                                                 state_q == SEND_UP,
                                                 (state_q == SEND_UP) ? up_id_q : down_id_q, mask_q);
                        end else begin
                            rd_ptr_q <= '0;
                            // Chain straight into the down pass so the link sees no bubble.
                            if ((state_q == SEND_UP) && has_down_q) begin
                                state_q <= SEND_DOWN;
                                data_q  <= mod_flit(mem_q[0], 1'b0, 1'b0, down_id_q, mask_q);
                            end else begin
                                state_q <= IDLE;
                                valid_q <= 1'b0;
                            end
                        end
                    end
                end
                DROP: begin
                    if (in_hs && data_i.hdr.last) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_floo_ring_on_mesh_mcast_injector.sv
// Bench for the ring-on-mesh multicast injector (16 nodes, 4-flit buffer, own id 5).
module tb_floo_ring_on_mesh_mcast_injector;

    typedef floo_pkg::ring_flit_t flit_t;
    localparam int N   = 16;
    localparam int M   = 4;
    localparam int OWN = 5;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [3:0]  ring_on_mesh_id_i;
    logic        valid_i, ready_o, valid_o, ready_i, busy_o, err_o;
    flit_t       data_i, data_o;
    logic        rdy_man, rdy_rand_q, rdy_rand_en;

    int          checks = 0;
    int          errors = 0;
    int          err_cnt = 0;
    flit_t       got_q[$];
    flit_t       exp_q[$];

    assign ready_i = rdy_rand_en ? rdy_rand_q : rdy_man;
    assign ring_on_mesh_id_i = 4'(OWN);

    floo_ring_on_mesh_mcast_injector #(
        .NumNodes (N),
        .MaxFlits (M),
        .flit_t   (flit_t)
    ) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .ring_on_mesh_id_i (ring_on_mesh_id_i),
        .valid_i           (valid_i),
        .ready_o           (ready_o),
        .data_i            (data_i),
        .valid_o           (valid_o),
        .ready_i           (ready_i),
        .data_o            (data_o),
        .busy_o            (busy_o),
        .err_o             (err_o)
    );

    initial forever #5 clk_i = ~clk_i;

    initial begin
        rdy_rand_q = 1'b1;
        forever begin
            @(posedge clk_i);
            #1;
            rdy_rand_q = 1'($urandom_range(0, 1));
        end
    end

    always @(negedge clk_i) begin
        if (!rst_i && valid_o && ready_i) got_q.push_back(data_o);
        if (err_o) err_cnt++;
    end

    typedef struct {
        int          n;
        bit          mc;
        logic [15:0] mask;
        logic [31:0] base;
        int          nout;
        logic [3:0]  dst;
        bit          up;
        int          err;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic flit_t mkflit(input int i, input int n, input bit mc,
                                     input logic [15:0] mask, input logic [31:0] base);
        flit_t f;
        f = '0;
        f.hdr.dst_id                = base[3:0];
        f.hdr.ring_on_mesh_mcast    = mc;
        f.hdr.ring_on_mesh_dst_mask = mask;
        f.hdr.up_down_traffic       = base[4];
        f.hdr.last                  = (i == n - 1);
        f.payload                   = base + 32'(i);
        return f;
    endfunction

    // Reference: expected output flit list and error pulse count for one packet.
    task automatic model(input int n, input bit mc, input logic [15:0] mask,
                         input logic [31:0] base, output int e);
        logic [15:0] m;
        int          up, dn;
        flit_t       f;
        exp_q.delete();
        e = 0;
        if (n > M) begin
            e = 1;
            return;
        end
        if (!mc) begin
            for (int i = 0; i < n; i++) exp_q.push_back(mkflit(i, n, mc, mask, base));
            return;
        end
        m = mask & ~(16'h0001 << OWN);
        if (m == 16'h0) begin
            e = 1;
            return;
        end
        up = -1;
        for (int b = OWN + 1; b < N; b++) if (m[b]) up = b;
        dn = -1;
        for (int b = OWN - 1; b >= 0; b--) if (m[b]) dn = b;
        if (up >= 0) begin
            for (int i = 0; i < n; i++) begin
                f = mkflit(i, n, mc, mask, base);
                f.hdr.dst_id = 4'(up);
                f.hdr.up_down_traffic = 1'b1;
                f.hdr.ring_on_mesh_dst_mask = m;
                exp_q.push_back(f);
            end
        end
        if (dn >= 0) begin
            for (int i = 0; i < n; i++) begin
                f = mkflit(i, n, mc, mask, base);
                f.hdr.dst_id = 4'(dn);
                f.hdr.up_down_traffic = 1'b0;
                f.hdr.ring_on_mesh_dst_mask = m;
                exp_q.push_back(f);
            end
        end
    endtask

    task automatic send_pkt(input int n, input bit mc, input logic [15:0] mask, input logic [31:0] base);
        int g;
        for (int i = 0; i < n; i++) begin
            valid_i = 1'b1;
            data_i  = mkflit(i, n, mc, mask, base);
            g = 0;
            @(negedge clk_i);
            while (!ready_o && g < 100) begin
                g++;
                @(negedge clk_i);
            end
            if (g >= 100) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout actual=stalled required=accepted flit=%0d", i);
            end
            @(posedge clk_i);
            #1;
        end
        valid_i = 1'b0;
        data_i  = '0;
    endtask

    task automatic run_pkt(input int n, input bit mc, input logic [15:0] mask, input logic [31:0] base,
                           input bit timing, output int nout, output int errs, output flit_t first);
        int e, gs, ec, cnt, guard;
        model(n, mc, mask, base, e);
        gs = got_q.size();
        ec = err_cnt;
        send_pkt(n, mc, mask, base);
        if (timing) begin
            @(negedge clk_i);
            chk("first_latency", valid_o, exp_q.size() > 0);
            cnt = 0;
            while (valid_o && cnt < 20) begin
                cnt++;
                @(negedge clk_i);
            end
            chk("gapless_len", cnt, exp_q.size());
            chk("busy_after", busy_o, 1'b0);
        end
        guard = 0;
        @(negedge clk_i);
        while ((busy_o || valid_o) && guard < 400) begin
            guard++;
            @(negedge clk_i);
        end
        chk("drain_in_time", guard < 400, 1'b1);
        repeat (2) @(negedge clk_i);
        nout = got_q.size() - gs;
        errs = err_cnt - ec;
        chk("out_count", nout, exp_q.size());
        chk("err_pulses", errs, e);
        for (int i = 0; i < nout && i < exp_q.size(); i++) chk("flit", got_q[gs + i], exp_q[i]);
        first = (nout > 0) ? got_q[gs] : '0;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        vec_t  vecs[7];
        int    nout, errs, e, gs, sz, g;
        flit_t first, held;
        bit    prev_stall;
        bit    mc;
        logic [15:0] mask;

        vecs[0] = '{2, 1'b1, 16'h0421, 32'h20,   4, 4'd10, 1'b1, 0};
        vecs[1] = '{1, 1'b1, 16'h0020, 32'h21,   0, 4'd0,  1'b0, 1};
        vecs[2] = '{1, 1'b1, 16'h8000, 32'h22,   1, 4'd15, 1'b1, 0};
        vecs[3] = '{3, 1'b0, 16'h0000, 32'h1033, 3, 4'd3,  1'b1, 0};
        vecs[4] = '{2, 1'b1, 16'h0003, 32'h40,   2, 4'd0,  1'b0, 0};
        vecs[5] = '{5, 1'b1, 16'h0421, 32'h50,   0, 4'd0,  1'b0, 1};
        vecs[6] = '{4, 1'b1, 16'h00C0, 32'h60,   4, 4'd7,  1'b1, 0};

        rst_i = 1'b1;
        valid_i = 1'b0;
        data_i = '0;
        rdy_man = 1'b1;
        rdy_rand_en = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_valid", valid_o, 1'b0);
        chk("rst_ready", ready_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_err", err_o, 1'b0);
        chk("rst_data", data_o, '0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("idle_ready", ready_o, 1'b1);
        @(posedge clk_i);
        #1;

        for (int k = 0; k < 7; k++) begin
            run_pkt(vecs[k].n, vecs[k].mc, vecs[k].mask, vecs[k].base, 1'b1, nout, errs, first);
            chk($sformatf("tbl%0d_nout", k), nout, vecs[k].nout);
            chk($sformatf("tbl%0d_err", k), errs, vecs[k].err);
            if (nout > 0) begin
                chk($sformatf("tbl%0d_dst", k), first.hdr.dst_id, vecs[k].dst);
                chk($sformatf("tbl%0d_up", k), first.hdr.up_down_traffic, vecs[k].up);
            end
        end

        // Unicast under a 1010 ready pattern: order preserved, outputs held while stalled.
        model(3, 1'b0, 16'h0, 32'h77, e);
        gs = got_q.size();
        rdy_man = 1'b0;
        send_pkt(3, 1'b0, 16'h0, 32'h77);
        prev_stall = 1'b0;
        held = '0;
        for (int k = 0; k < 12; k++) begin
            rdy_man = (k % 2 == 0);
            @(negedge clk_i);
            if (prev_stall) begin
                chk("stall_valid", valid_o, 1'b1);
                chk("stall_data", data_o, held);
            end
            prev_stall = valid_o && !ready_i;
            held = data_o;
            @(posedge clk_i);
            #1;
        end
        rdy_man = 1'b1;
        repeat (2) @(negedge clk_i);
        chk("ucast_count", got_q.size() - gs, exp_q.size());
        for (int i = 0; i < exp_q.size() && gs + i < got_q.size(); i++) chk("ucast_flit", got_q[gs + i], exp_q[i]);
        @(posedge clk_i);
        #1;

        // Reset while the down pass is on the link.
        send_pkt(2, 1'b1, 16'h0421, 32'h90);
        g = 0;
        @(negedge clk_i);
        while (!(valid_o && !data_o.hdr.up_down_traffic) && g < 20) begin
            g++;
            @(negedge clk_i);
        end
        chk("reached_down", g < 20, 1'b1);
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("midrst_valid", valid_o, 1'b0);
        chk("midrst_busy", busy_o, 1'b0);
        chk("midrst_ready", ready_o, 1'b0);
        sz = got_q.size();
        rst_i = 1'b0;
        repeat (10) @(negedge clk_i);
        chk("midrst_no_more", got_q.size() - sz, 0);
        chk("midrst_idle_valid", valid_o, 1'b0);
        @(posedge clk_i);
        #1;

        rdy_rand_en = 1'b1;
        for (int k = 0; k < 40; k++) begin
            mc = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0:       mask = 16'h0020;
                1:       mask = 16'h0001 << $urandom_range(0, 15);
                default: mask = 16'($urandom);
            endcase
            run_pkt($urandom_range(1, 5), mc, mask, $urandom, 1'b0, nout, errs, first);
        end
        rdy_rand_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
